// File: rtl/regfile_mp.sv
// regfile_mp: multi-port byte-strobed register file with pending scoreboard and soft-clear engine.
// Optional macro REGFILE_MP_BYPASS_EN enables same-cycle write-to-read bypass of data and pending.
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int N_REGS     = 32,
    parameter int N_RD       = 2,
    parameter int N_WR       = 2,
    parameter int ADDR_W     = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_RD*ADDR_W-1:0]       rs_addr,
    output logic [N_RD*DATA_WIDTH-1:0]   rs_data,
    output logic [N_RD-1:0]              rs_pending,
    input  logic [N_WR-1:0]              wr_en,
    input  logic [N_WR*ADDR_W-1:0]       wr_addr,
    input  logic [N_WR*DATA_WIDTH-1:0]   wr_data,
    input  logic [N_WR*DATA_WIDTH/8-1:0] wr_strb,
    input  logic                         sb_set,
    input  logic [ADDR_W-1:0]            sb_addr,
    input  logic                         clr_req,
    output logic                         clr_busy,
    output logic                         clr_done
);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state, state_nxt;
    logic [ADDR_W-1:0]     cnt;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] regs [N_REGS];
    logic [N_REGS-1:0]     pending;
    logic [N_REGS-1:0]     pend_nxt;
    logic [N_WR-1:0]       wr_acc;
    logic [N_REGS-1:0]     wr_hit;
    logic [N_REGS-1:0]     sb_hit;

    function automatic logic idx_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && (32'(a) < N_REGS);
    endfunction

    // Write acceptance and per-register scoreboard hits; all suppressed while clearing.
    always_comb begin
        wr_acc = '0;
        wr_hit = '0;
        sb_hit = '0;
        for (int p = 0; p < N_WR; p++) begin
            wr_acc[p] = wr_en[p] && idx_ok(wr_addr[p*ADDR_W +: ADDR_W]) && (state == IDLE);
            for (int r = 1; r < N_REGS; r++)
                if (wr_acc[p] && wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r))
                    wr_hit[r] = 1'b1;
        end
        for (int r = 1; r < N_REGS; r++)
            if (sb_set && (state == IDLE) && sb_addr == ADDR_W'(r))
                sb_hit[r] = 1'b1;
        pend_nxt = (pending & ~wr_hit) | sb_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == CLEAR) && (cnt == ADDR_W'(N_REGS - 1));
            if (state == IDLE)
                cnt <= ADDR_W'(1);
            else
                cnt <= cnt + ADDR_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = CLEAR;
            CLEAR:   if (cnt == ADDR_W'(N_REGS - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign clr_busy = (state == CLEAR);
    assign clr_done = done_q;

    // Ports are visited in ascending order so the higher port wins each byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N_REGS; r++)
                regs[r] <= '0;
            pending <= '0;
        end else if (state == CLEAR) begin
            for (int r = 0; r < N_REGS; r++)
                if (cnt == ADDR_W'(r)) begin
                    regs[r]    <= '0;
                    pending[r] <= 1'b0;
                end
        end else begin
            for (int r = 1; r < N_REGS; r++)
                for (int p = 0; p < N_WR; p++)
                    if (wr_acc[p] && wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r))
                        for (int b = 0; b < NB; b++)
                            if (wr_strb[p*NB + b])
                                regs[r][b*8 +: 8] <= wr_data[p*DATA_WIDTH + b*8 +: 8];
            pending <= pend_nxt;
        end
    end

    // Register 0 is never written, so it reads back as zero with no special case.
    always_comb begin
        rs_data    = '0;
        rs_pending = '0;
        for (int k = 0; k < N_RD; k++)
            for (int r = 0; r < N_REGS; r++)
                if (rs_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                    rs_data[k*DATA_WIDTH +: DATA_WIDTH] = regs[r];
`ifdef REGFILE_MP_BYPASS_EN
                    rs_pending[k] = wr_hit[r] ? sb_hit[r] : pending[r];
                    for (int p = 0; p < N_WR; p++)
                        if (wr_acc[p] && wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(r))
                            for (int b = 0; b < NB; b++)
                                if (wr_strb[p*NB + b])
                                    rs_data[k*DATA_WIDTH + b*8 +: 8] = wr_data[p*DATA_WIDTH + b*8 +: 8];
`else
                    rs_pending[k] = pending[r];
`endif
                end
    end

endmodule
